airlock_sequencer: RTL and testbench
====================================

Name: airlock_sequencer

Overview:
- Controller for the airlock chamber pressure datapath.
- Arbitrates two level requesters, enter (from the vacuum side) and exit (from the habitat side).
- Drives the chamber's start_press/start_depress controls and sequences inner and outer door open windows around the target pressures.
- Sits between the door request logic and the pressure datapath; reads back the 8-bit chamber pressure.

Parameters:
PRESS_MAX, 8'hFF, pressure at which the inner (habitat) door may open
PRESS_MIN, 8'h00, pressure at which the outer (vacuum) door may open
DOOR_CYCLES, 4, clock cycles each door stays open (1..255)
TIMEOUT_CYCLES, 4096, pump watchdog limit; used only with AIRLOCK_WATCHDOG_EN

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pressure  in  8  current chamber pressure from the pressure datapath
req_enter  in  1  level request: move from vacuum side into habitat
req_exit  in  1  level request: move from habitat out to vacuum
start_press  out  1  held high while the chamber must pressurize
start_depress  out  1  held high while the chamber must depressurize
outer_open  out  1  outer door open command
inner_open  out  1  inner door open command
grant_enter  out  1  enter request owns the airlock
grant_exit  out  1  exit request owns the airlock
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a sequence completes
fault  out  1  watchdog trip (constant 0 without AIRLOCK_WATCHDOG_EN)

Behaviour:
- All outputs are registered. Reset takes effect on the clock edge: state=IDLE, all outputs 0, last_grant=enter (next tie goes to exit), hold counter 0.
- States: IDLE, PUMP1, OPEN1, PUMP2, OPEN2, FAULT.
- Enter sequence:
  - leg1: depressurize to PRESS_MIN, then open the outer door.
  - leg2: pressurize to PRESS_MAX, then open the inner door.
- Exit sequence: the mirror of enter (leg1 to PRESS_MAX / inner door; leg2 to PRESS_MIN / outer door).
- IDLE arbitration:
  - One request → granted.
  - Both requests → the one not equal to last_grant wins (round robin).
  - The grant latches on the edge and is held until the return to IDLE. last_grant updates at grant.
- Pump skip: if pressure already equals the leg's target on the grant edge, go straight to OPEN1 (skip PUMP1). The same rule applies on entry to PUMP2.
- PUMPn:
  - The matching start_* output is high.
  - On the cycle pressure == target, the next edge drops start_* and enters OPENn.
  - The 7/8-cycle datapath step guarantees no overshoot or wrap-around.
  - Never assert start_press and start_depress together.
- OPENn:
  - The door output is high for exactly DOOR_CYCLES cycles, then goes low on the edge that leaves the state.
  - Door outputs are never both high. A door is never high while pressure != that door's target.
- OPEN2 exit → IDLE, done=1 for one cycle, grants cleared. A new request may be granted on the next edge.
- Request deassertion mid-sequence is ignored; the sequence completes.
- Pressure changing away from target during OPENn: close the door immediately and return to PUMPn.
- Reset mid-sequence: all outputs low on that edge; the pressure datapath is reset separately.

Optional Feature:
- Macro AIRLOCK_WATCHDOG_EN.
- Defined:
  - A 13-bit counter clears on PUMPn entry and counts while in PUMPn.
  - Reaching TIMEOUT_CYCLES → FAULT: start_*, doors and grants low; fault=1, busy=1.
  - FAULT is left only by reset.
- Undefined: no counter; FAULT is unreachable; fault tied 0.

Decomposition:
- Package airlock_pkg holds:
  - state enum (IDLE, PUMP1, OPEN1, PUMP2, OPEN2, FAULT)
  - requester enum (REQ_ENTER, REQ_EXIT)
  - default PRESS_MAX/PRESS_MIN constants
  - width constant PRESS_W=8
- One sub-module, door_timer:
  - load/count-down hold counter for DOOR_CYCLES, with an expired flag.
  - Reused for the watchdog when enabled.

Test Plan:
- Reset, pressure=FF, req_exit=1 → grant_exit next cycle, PUMP1 skipped, inner_open high 4 cycles, then start_depress high until pressure=00, outer_open 4 cycles, done pulse, busy=0.
- pressure=FF, req_enter=1 → start_depress until 00 (no underflow to FF), outer_open 4 cycles, start_press until FF, inner_open 4 cycles, done.
- req_enter and req_exit both high at IDLE after reset → exit granted first; enter granted on the edge after done.
- Drop req_enter during PUMP1 → sequence still completes, done pulses once.
- Assert reset during OPEN1 → all outputs 0 on that edge, state IDLE.
- AIRLOCK_WATCHDOG_EN, TIMEOUT_CYCLES=16, pressure held at 80 in PUMP1 → fault=1 after 16 cycles, start_* low; stays until reset.

Source files
------------

// File: rtl/airlock_sequencer_pkg.sv
// rtl/airlock_sequencer_pkg.sv - shared types and constants for the airlock sequencer
package airlock_pkg;

    localparam int PRESS_W = 8;
    localparam logic [PRESS_W-1:0] PRESS_MAX_DEF = 8'hFF;
    localparam logic [PRESS_W-1:0] PRESS_MIN_DEF = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        PUMP1,
        OPEN1,
        PUMP2,
        OPEN2,
        FAULT
    } state_t;

    typedef enum logic {
        REQ_ENTER,
        REQ_EXIT
    } req_t;

    // Enter depressurizes first, exit pressurizes first; the second leg is the opposite.
    function automatic logic leg_pressurizes(req_t owner, logic second_leg);
        return (owner == REQ_EXIT) ^ second_leg;
    endfunction

endpackage

// File: rtl/airlock_sequencer_if.sv
// rtl/airlock_sequencer_if.sv - door request / pressure datapath signal bundle
interface airlock_sequencer_if;

    logic [airlock_pkg::PRESS_W-1:0] pressure;
    logic req_enter;
    logic req_exit;
    logic start_press;
    logic start_depress;
    logic outer_open;
    logic inner_open;
    logic grant_enter;
    logic grant_exit;
    logic busy;
    logic done;
    logic fault;

    modport master (
        output pressure, req_enter, req_exit,
        input  start_press, start_depress, outer_open, inner_open,
        input  grant_enter, grant_exit, busy, done, fault
    );

    modport slave (
        input  pressure, req_enter, req_exit,
        output start_press, start_depress, outer_open, inner_open,
        output grant_enter, grant_exit, busy, done, fault
    );

endinterface

// File: rtl/airlock_sequencer_door_timer.sv
// rtl/airlock_sequencer_door_timer.sv - load/count-down hold counter with expired flag
module door_timer #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/airlock_sequencer.sv
// rtl/airlock_sequencer.sv - airlock door/pump sequencer; optional pump watchdog via AIRLOCK_WATCHDOG_EN
module airlock_sequencer
    import airlock_pkg::*;
#(
    parameter logic [PRESS_W-1:0] PRESS_MAX   = PRESS_MAX_DEF,
    parameter logic [PRESS_W-1:0] PRESS_MIN   = PRESS_MIN_DEF,
    parameter int unsigned        DOOR_CYCLES = 4
`ifdef AIRLOCK_WATCHDOG_EN
    ,
    parameter int unsigned        TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic               clock,
    input  logic               reset,
    airlock_sequencer_if.slave bus
);

    localparam logic [7:0] DOOR_LOAD = 8'(DOOR_CYCLES - 1);

    state_t r_state, w_next_state;
    req_t   r_owner, w_next_owner, r_last_grant, w_next_last;
    logic   w_cur_second, w_at_target, w_in_pump, w_in_open;
    logic   w_next_second, w_next_press, w_next_pump, w_next_open;
    logic   w_door_load, w_door_expired, w_wd_trip;
    logic   r_start_press, r_start_depress, r_outer_open, r_inner_open;
    logic   r_grant_enter, r_grant_exit, r_busy, r_done;

    function automatic logic leg_at_target(logic [PRESS_W-1:0] p, req_t owner, logic second);
        return p == (leg_pressurizes(owner, second) ? PRESS_MAX : PRESS_MIN);
    endfunction

    assign w_cur_second = (r_state == PUMP2) || (r_state == OPEN2);
    assign w_in_pump    = (r_state == PUMP1) || (r_state == PUMP2);
    assign w_in_open    = (r_state == OPEN1) || (r_state == OPEN2);
    assign w_at_target  = leg_at_target(bus.pressure, r_owner, w_cur_second);

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last_grant;
        case (r_state)
            IDLE: begin
                if (bus.req_enter || bus.req_exit) begin
                    // Simultaneous requests alternate with the previous winner.
                    if (bus.req_enter && bus.req_exit)
                        w_next_owner = (r_last_grant == REQ_ENTER) ? REQ_EXIT : REQ_ENTER;
                    else
                        w_next_owner = bus.req_exit ? REQ_EXIT : REQ_ENTER;
                    w_next_last  = w_next_owner;
                    w_next_state = leg_at_target(bus.pressure, w_next_owner, 1'b0) ? OPEN1 : PUMP1;
                end
            end
            PUMP1: begin
                if (w_at_target)    w_next_state = OPEN1;
                else if (w_wd_trip) w_next_state = FAULT;
            end
            OPEN1: begin
                if (!w_at_target)
                    w_next_state = PUMP1;
                else if (w_door_expired)
                    w_next_state = leg_at_target(bus.pressure, r_owner, 1'b1) ? OPEN2 : PUMP2;
            end
            PUMP2: begin
                if (w_at_target)    w_next_state = OPEN2;
                else if (w_wd_trip) w_next_state = FAULT;
            end
            OPEN2: begin
                if (!w_at_target)        w_next_state = PUMP2;
                else if (w_door_expired) w_next_state = IDLE;
            end
            FAULT:   w_next_state = FAULT;
            default: w_next_state = IDLE;
        endcase
        w_next_second = (w_next_state == PUMP2) || (w_next_state == OPEN2);
        w_next_press  = leg_pressurizes(w_next_owner, w_next_second);
        w_next_pump   = (w_next_state == PUMP1) || (w_next_state == PUMP2);
        w_next_open   = (w_next_state == OPEN1) || (w_next_state == OPEN2);
        w_door_load   = w_next_open && (w_next_state != r_state);
    end

    door_timer #(.W(8)) u_door_timer (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_door_load),
        .i_load_val (DOOR_LOAD),
        .i_count    (w_in_open),
        .o_expired  (w_door_expired)
    );

`ifdef AIRLOCK_WATCHDOG_EN
    localparam logic [12:0] WD_LOAD = 13'(TIMEOUT_CYCLES - 1);
    logic w_wd_expired;
    logic r_fault;

    door_timer #(.W(13)) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_next_pump && (w_next_state != r_state)),
        .i_load_val (WD_LOAD),
        .i_count    (w_in_pump),
        .o_expired  (w_wd_expired)
    );

    assign w_wd_trip = w_wd_expired && w_in_pump;

    always_ff @(posedge clock) begin
        if (reset) r_fault <= 1'b0;
        else       r_fault <= (w_next_state == FAULT);
    end

    assign bus.fault = r_fault;
`else
    assign w_wd_trip = 1'b0;
    assign bus.fault = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_owner         <= REQ_ENTER;
            r_last_grant    <= REQ_ENTER;
            r_start_press   <= 1'b0;
            r_start_depress <= 1'b0;
            r_outer_open    <= 1'b0;
            r_inner_open    <= 1'b0;
            r_grant_enter   <= 1'b0;
            r_grant_exit    <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_owner         <= w_next_owner;
            r_last_grant    <= w_next_last;
            r_start_press   <= w_next_pump && w_next_press;
            r_start_depress <= w_next_pump && !w_next_press;
            r_inner_open    <= w_next_open && w_next_press;
            r_outer_open    <= w_next_open && !w_next_press;
            r_grant_enter   <= (w_next_pump || w_next_open) && (w_next_owner == REQ_ENTER);
            r_grant_exit    <= (w_next_pump || w_next_open) && (w_next_owner == REQ_EXIT);
            r_busy          <= (w_next_state != IDLE);
            r_done          <= (r_state == OPEN2) && (w_next_state == IDLE);
        end
    end

    assign bus.start_press   = r_start_press;
    assign bus.start_depress = r_start_depress;
    assign bus.outer_open    = r_outer_open;
    assign bus.inner_open    = r_inner_open;
    assign bus.grant_enter   = r_grant_enter;
    assign bus.grant_exit    = r_grant_exit;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb/tb_airlock_sequencer.sv - randomized airlock sequencer bench with a leg-list reference model
module tb_airlock_sequencer;

    localparam int DOOR = 4;
    localparam int TMO  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    airlock_sequencer_if bus_if ();

    airlock_sequencer #(
        .DOOR_CYCLES (DOOR)
`ifdef AIRLOCK_WATCHDOG_EN
        , .TIMEOUT_CYCLES (TMO)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit freeze = 1'b0;
    bit perturb = 1'b0;

    bit m_active, m_exit, m_open, m_last_exit, m_done, m_fault;
    int m_leg, m_left, m_pump_n;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_press_leg();
        return m_exit ^ (m_leg == 1);
    endfunction

    function automatic logic [7:0] m_target();
        return m_press_leg() ? 8'hFF : 8'h00;
    endfunction

    task automatic model_reset();
        m_active = 0; m_exit = 0; m_open = 0; m_last_exit = 0;
        m_done = 0; m_fault = 0; m_leg = 0; m_left = 0; m_pump_n = 0;
    endtask

    task automatic enter_leg(input logic [7:0] p);
        m_open   = (p == m_target());
        m_left   = DOOR;
        m_pump_n = 0;
    endtask

    task automatic model_step(input logic [7:0] p, input bit re, input bit rx);
        m_done = 0;
        if (m_fault) return;
        if (!m_active) begin
            if (re || rx) begin
                m_exit      = (re && rx) ? !m_last_exit : rx;
                m_last_exit = m_exit;
                m_active    = 1;
                m_leg       = 0;
                enter_leg(p);
            end
        end else if (!m_open) begin
            if (p == m_target()) begin
                m_open = 1;
                m_left = DOOR;
            end else begin
                m_pump_n++;
`ifdef AIRLOCK_WATCHDOG_EN
                if (m_pump_n == TMO) begin
                    m_fault  = 1;
                    m_active = 0;
                end
`endif
            end
        end else if (p != m_target()) begin
            m_open   = 0;
            m_pump_n = 0;
        end else if (m_left > 1) begin
            m_left--;
        end else if (m_leg == 0) begin
            m_leg = 1;
            enter_leg(p);
        end else begin
            m_active = 0;
            m_done   = 1;
        end
    endtask

    function automatic logic [8:0] exp_vec();
        bit pump, pl;
        pump = m_active && !m_open;
        pl   = m_press_leg();
        return {m_fault, m_active || m_fault, m_done, m_active && m_exit, m_active && !m_exit,
                m_active && m_open && pl, m_active && m_open && !pl, pump && !pl, pump && pl};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {bus_if.fault, bus_if.busy, bus_if.done, bus_if.grant_exit, bus_if.grant_enter,
                bus_if.inner_open, bus_if.outer_open, bus_if.start_depress, bus_if.start_press};
    endfunction

    task automatic plant();
        int tmp;
        bit pump;
        pump = m_active && !m_open;
        if (freeze) return;
        if (perturb && m_active && m_open && ($urandom_range(0, 31) == 0)) begin
            bus_if.pressure = 8'($urandom);
        end else if (pump && m_press_leg()) begin
            tmp = int'(bus_if.pressure) + int'($urandom_range(1, 48));
            bus_if.pressure = (tmp > 255) ? 8'hFF : 8'(tmp);
        end else if (pump) begin
            tmp = int'(bus_if.pressure) - int'($urandom_range(1, 48));
            bus_if.pressure = (tmp < 0) ? 8'h00 : 8'(tmp);
        end else if (perturb && !m_active && ($urandom_range(0, 7) == 0)) begin
            case ($urandom_range(0, 2))
                0:       bus_if.pressure = 8'hFF;
                1:       bus_if.pressure = 8'h00;
                default: bus_if.pressure = 8'($urandom);
            endcase
        end
    endtask

    task automatic cycle();
        logic [7:0] p;
        bit re, rx, rs;
        p  = bus_if.pressure;
        re = bus_if.req_enter;
        rx = bus_if.req_exit;
        rs = reset;
        @(posedge clock);
        if (rs) model_reset();
        else    model_step(p, re, rx);
        @(negedge clock);
        check("outputs", 16'(dut_vec()), 16'(exp_vec()));
        check("pump_excl", 16'(bus_if.start_press & bus_if.start_depress), 16'd0);
        check("door_excl", 16'(bus_if.inner_open & bus_if.outer_open), 16'd0);
        plant();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && m_active; i++) cycle();
        check("idle_busy", 16'(bus_if.busy), 16'd0);
    endtask

    initial begin
        int dones;
        model_reset();
        bus_if.pressure  = 8'h00;
        bus_if.req_enter = 1'b0;
        bus_if.req_exit  = 1'b0;
        @(negedge clock);
        do_reset();
        check("reset_state", 16'(dut_vec()), 16'd0);

        // exit from a pressurized chamber skips the first pump
        bus_if.pressure = 8'hFF;
        bus_if.req_exit = 1'b1;
        cycle();
        bus_if.req_exit = 1'b0;
        check("exit_grant", 16'(bus_if.grant_exit), 16'd1);
        check("exit_skip_pump1", 16'(bus_if.inner_open), 16'd1);
        check("exit_no_press", 16'(bus_if.start_press), 16'd0);
        wait_idle();
        check("exit_end_vacuum", 16'(bus_if.pressure), 16'h00);

        // full enter: depressurize then pressurize
        bus_if.pressure  = 8'hFF;
        bus_if.req_enter = 1'b1;
        cycle();
        bus_if.req_enter = 1'b0;
        check("enter_depress", 16'(bus_if.start_depress), 16'd1);
        wait_idle();
        check("enter_end_full", 16'(bus_if.pressure), 16'hFF);

        // tie after reset goes to exit, then enter right after done
        do_reset();
        bus_if.req_enter = 1'b1;
        bus_if.req_exit  = 1'b1;
        cycle();
        check("tie_exit_first", 16'(bus_if.grant_exit), 16'd1);
        for (int i = 0; i < 400 && !m_done; i++) cycle();
        check("tie_done", 16'(bus_if.done), 16'd1);
        cycle();
        check("tie_enter_next", 16'(bus_if.grant_enter), 16'd1);
        bus_if.req_enter = 1'b0;
        bus_if.req_exit  = 1'b0;
        wait_idle();

        // dropping the request mid-pump still completes exactly once
        bus_if.pressure  = 8'hFF;
        bus_if.req_enter = 1'b1;
        cycle();
        bus_if.req_enter = 1'b0;
        dones = 0;
        for (int i = 0; i < 200; i++) begin
            cycle();
            if (bus_if.done) dones++;
        end
        check("drop_done_once", 16'(dones), 16'd1);

        // reset while the outer door is open
        bus_if.pressure  = 8'h00;
        bus_if.req_enter = 1'b1;
        cycle();
        bus_if.req_enter = 1'b0;
        cycle();
        check("pre_reset_open1", 16'(bus_if.outer_open), 16'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("reset_open1", 16'(dut_vec()), 16'd0);

        // randomized traffic with pressure disturbances and occasional resets
        perturb = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) bus_if.req_enter = ~bus_if.req_enter;
            if ($urandom_range(0, 9) == 0) bus_if.req_exit  = ~bus_if.req_exit;
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;
        perturb = 1'b0;
        bus_if.req_enter = 1'b0;
        bus_if.req_exit  = 1'b0;

`ifdef AIRLOCK_WATCHDOG_EN
        do_reset();
        freeze = 1'b1;
        bus_if.pressure  = 8'h80;
        bus_if.req_enter = 1'b1;
        cycle();
        bus_if.req_enter = 1'b0;
        repeat (TMO - 1) cycle();
        check("wd_not_yet", 16'(bus_if.fault), 16'd0);
        cycle();
        check("wd_fault", 16'(bus_if.fault), 16'd1);
        check("wd_pump_off", 16'(bus_if.start_depress), 16'd0);
        repeat (5) cycle();
        check("wd_sticky", 16'(bus_if.fault), 16'd1);
        do_reset();
        check("wd_cleared", 16'(bus_if.fault), 16'd0);
        freeze = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
